cam_capture: RTL

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_pkg.sv | 22 ++
 rtl/cam_capture_if.sv | 23 ++
 rtl/cam_sync_edge.sv | 23 ++
 rtl/cam_capture.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared camera capture types and frame geometry defaults
package cam_pkg;

    localparam int CAM_IMG_W = 176;
    localparam int CAM_IMG_H = 144;
    localparam int CAM_DW    = 12;
    localparam int CAM_AW    = 15;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        WAIT_LINE  = 2'd1,
        BYTE_HI    = 2'd2,
        BYTE_LO    = 2'd3
    } cam_state_e;

    function automatic logic [11:0] cam_rgb444(input logic [3:0] r,
                                               input logic [3:0] g,
                                               input logic [3:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/cam_capture_if.sv
// rtl/cam_capture_if.sv - camera byte bus in, frame-buffer write port out
interface cam_capture_if #(
    parameter int DW = cam_pkg::CAM_DW,
    parameter int AW = cam_pkg::CAM_AW
);
    logic          Vsync;
    logic          Href;
    logic [7:0]    Data;
    logic [DW-1:0] DataRamIn;
    logic [AW-1:0] AddrRamIn;
    logic          WriteEn;
    logic          FrameDone;

    modport master (
        output Vsync, Href, Data,
        input  DataRamIn, AddrRamIn, WriteEn, FrameDone
    );

    modport slave (
        input  Vsync, Href, Data,
        output DataRamIn, AddrRamIn, WriteEn, FrameDone
    );
endinterface

// File: rtl/cam_sync_edge.sv
// rtl/cam_sync_edge.sv - registered previous value with rise/fall pulses
module cam_sync_edge (
    input  logic Clock,
    input  logic Reset,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;
    assign fall_o = ~sig_i & prev_q;

endmodule

// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - camera RGB444 byte-pair capture into a frame buffer
// Optional CAM_CAPTURE_TESTPATTERN_EN replaces camera colour with a coordinate pattern.
module cam_capture
    import cam_pkg::*;
#(
    parameter int IMG_W = CAM_IMG_W,
    parameter int IMG_H = CAM_IMG_H,
    parameter int DW    = CAM_DW,
    parameter int AW    = CAM_AW
) (
    input logic           Clock,
    input logic           Reset,
    cam_capture_if.slave  cam
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);

    cam_state_e    state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [3:0]    r_q, r_d;
    logic          has_px_q, has_px_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic          fd_q, fd_d;

    logic          vs_rise, vs_fall;
    logic          hr_rise, hr_fall;
    logic [11:0]   pix_rgb;
    logic [AW-1:0] pix_addr;
    logic          in_range;

    cam_sync_edge u_vsync_edge (
        .Clock  (Clock),
        .Reset  (Reset),
        .sig_i  (cam.Vsync),
        .rise_o (vs_rise),
        .fall_o (vs_fall)
    );

    cam_sync_edge u_href_edge (
        .Clock  (Clock),
        .Reset  (Reset),
        .sig_i  (cam.Href),
        .rise_o (hr_rise),
        .fall_o (hr_fall)
    );

`ifdef CAM_CAPTURE_TESTPATTERN_EN
    logic [15:0] x_ext, y_ext;
    assign x_ext   = 16'(x_q);
    assign y_ext   = 16'(y_q);
    assign pix_rgb = cam_rgb444(x_ext[7:4], y_ext[7:4],
                                (x_q == '0 || y_q == '0) ? 4'hF : 4'h0);
`else
    assign pix_rgb = cam_rgb444(r_q, cam.Data[7:4], cam.Data[3:0]);
`endif

    assign pix_addr = AW'(x_q) + AW'(y_q) * AW'(IMG_W);
    assign in_range = (x_q < XW'(IMG_W)) && (y_q < YW'(IMG_H));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= WAIT_FRAME;
            x_q      <= '0;
            y_q      <= '0;
            r_q      <= '0;
            has_px_q <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            r_q      <= r_d;
            has_px_q <= has_px_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            fd_q     <= fd_d;
        end
    end

    // Vsync rise outranks every line/byte event so a frame end always aborts.
    always_comb begin
        state_d = state_q;
        if (state_q == WAIT_FRAME) begin
            if (vs_fall) state_d = WAIT_LINE;
        end else if (vs_rise) begin
            state_d = WAIT_FRAME;
        end else begin
            unique case (state_q)
                WAIT_LINE: if (cam.Href) state_d = BYTE_LO;
                BYTE_LO: begin
                    if (hr_fall)       state_d = WAIT_LINE;
                    else if (cam.Href) state_d = BYTE_HI;
                end
                BYTE_HI: begin
                    if (hr_fall)       state_d = WAIT_LINE;
                    else if (cam.Href) state_d = BYTE_LO;
                end
                default: state_d = WAIT_FRAME;
            endcase
        end
    end

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        r_d      = r_q;
        has_px_d = has_px_q;
        data_d   = data_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        fd_d     = 1'b0;
        if (state_q == WAIT_FRAME) begin
            if (vs_fall) begin
                x_d      = '0;
                y_d      = '0;
                has_px_d = 1'b0;
            end
        end else if (vs_rise) begin
            fd_d = (y_q != '0);
        end else if (state_q == WAIT_LINE) begin
            if (cam.Href) begin
                r_d      = cam.Data[3:0];
                has_px_d = 1'b0;
            end
        end else if (hr_fall) begin
            // A high byte still waiting for its partner is simply dropped here.
            x_d = '0;
            if (has_px_q && (y_q < YW'(IMG_H))) y_d = y_q + YW'(1);
        end else if (cam.Href) begin
            if (state_q == BYTE_HI) begin
                r_d = cam.Data[3:0];
            end else begin
                has_px_d = 1'b1;
                if (in_range) begin
                    we_d   = 1'b1;
                    data_d = DW'(pix_rgb);
                    addr_d = pix_addr;
                end
                if (x_q < XW'(IMG_W)) x_d = x_q + XW'(1);
            end
        end
    end

    assign cam.DataRamIn = data_q;
    assign cam.AddrRamIn = addr_q;
    assign cam.WriteEn   = we_q;
    assign cam.FrameDone = fd_q;

    logic unused_ok;
    assign unused_ok = hr_rise;

endmodule
